// File: rtl/stopwatch_ctrl_if.sv
// Button, counter-chain and display signals of the stopwatch controller.
// The lap input exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        up_dn_in;
  logic [15:0] preset;
  logic [3:0]  thr;
  logic [15:0] digits;
  logic [3:0]  en;
  logic        up_dn;
  logic        cnt_rst;
  logic [15:0] rst_val;
  logic        running;
  logic        done;
  logic [15:0] disp_digits;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
`endif

  modport master (
`ifdef STOPWATCH_LAP_EN
    input  lap,
`endif
    input  start, stop, clear, up_dn_in, preset, thr, digits,
    output en, up_dn, cnt_rst, rst_val, running, done, disp_digits
  );

  modport slave (
`ifdef STOPWATCH_LAP_EN
    output lap,
`endif
    output start, stop, clear, up_dn_in, preset, thr, digits,
    input  en, up_dn, cnt_rst, rst_val, running, done, disp_digits
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for the MM:SS BCD counter chain with 1 Hz prescaler.
// Optional lap-hold display feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int TICK_W   = 27
) (
  input logic              clk,
  input logic              reset,
  stopwatch_ctrl_if.master sw
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]        state, state_nxt;
  logic [TICK_W-1:0] prescaler, prescaler_nxt;
  logic              up_dn_q;
  logic              cnt_rst_q;
  logic [15:0]       rst_val_q;
  logic              term;
  logic              tick;
  logic [3:0]        en_c;

  assign term = &sw.thr;
  assign tick = (state == RUN) && (prescaler == TICK_LAST);

  // Clear always wins; stop outranks start; a terminal count ends the run.
  always_comb begin
    state_nxt     = state;
    prescaler_nxt = prescaler;
    case (state)
      IDLE: begin
        if (sw.clear) begin
          prescaler_nxt = '0;
        end else if (sw.start && !term) begin
          state_nxt     = RUN;
          prescaler_nxt = '0;
        end
      end
      RUN: begin
        if (sw.clear) begin
          state_nxt     = IDLE;
          prescaler_nxt = '0;
        end else if (sw.stop) begin
          state_nxt = PAUSE;
        end else if (term) begin
          state_nxt = DONE;
        end else begin
          prescaler_nxt = tick ? '0 : prescaler + TICK_W'(1);
        end
      end
      PAUSE: begin
        if (sw.clear) begin
          state_nxt     = IDLE;
          prescaler_nxt = '0;
        end else if (sw.start) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (sw.clear) begin
          state_nxt     = IDLE;
          prescaler_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        prescaler_nxt = '0;
      end
    endcase
  end

  // Reset leaves cnt_rst high for one cycle so the counters start from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      up_dn_q   <= 1'b1;
      cnt_rst_q <= 1'b1;
      rst_val_q <= '0;
    end else begin
      state     <= state_nxt;
      prescaler <= prescaler_nxt;
      cnt_rst_q <= sw.clear;
      if (sw.clear) begin
        rst_val_q <= up_dn_q ? 16'h0000 : sw.preset;
      end
      if (state == IDLE) begin
        up_dn_q <= sw.up_dn_in;
      end
    end
  end

  always_comb begin
    en_c    = '0;
    en_c[0] = tick & ~term;
    en_c[1] = en_c[0] & sw.thr[0];
    en_c[2] = en_c[1] & sw.thr[1];
    en_c[3] = en_c[2] & sw.thr[2];
  end

  assign sw.en      = en_c;
  assign sw.up_dn   = up_dn_q;
  assign sw.cnt_rst = cnt_rst_q;
  assign sw.rst_val = rst_val_q;
  assign sw.running = (state == RUN);
  assign sw.done    = (state == DONE);

`ifdef STOPWATCH_LAP_EN
  logic        hold;
  logic [15:0] lap_reg;

  // A lap press freezes the display while running; the next press releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold    <= 1'b0;
      lap_reg <= '0;
    end else if (sw.clear) begin
      hold <= 1'b0;
    end else if (sw.lap) begin
      if (hold) begin
        hold <= 1'b0;
      end else if (state == RUN) begin
        hold    <= 1'b1;
        lap_reg <= sw.digits;
      end
    end
  end

  assign sw.disp_digits = hold ? lap_reg : sw.digits;
`else
  assign sw.disp_digits = sw.digits;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a behavioural BCD counter chain.
// Exercises the lap feature too when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int TICK_W   = 3;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw)
  );

  always #5 clk = ~clk;

  // Digit counters: even index = ones (0..9), odd index = tens (0..5).
  logic [3:0] cd [4] = '{default: 4'd0};
  logic [3:0] thr_m;

  function automatic logic [3:0] dmax(input int i);
    return (i % 2 == 0) ? 4'd9 : 4'd5;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sw.cnt_rst === 1'b1) begin
        cd[i] <= sw.rst_val[4*i +: 4];
      end else if (sw.en[i] === 1'b1) begin
        if (sw.up_dn) cd[i] <= (cd[i] == dmax(i)) ? 4'd0 : cd[i] + 4'd1;
        else          cd[i] <= (cd[i] == 4'd0) ? dmax(i) : cd[i] - 4'd1;
      end
    end
  end

  always_comb begin
    thr_m = '0;
    for (int i = 0; i < 4; i++) begin
      thr_m[i] = sw.up_dn ? (cd[i] == dmax(i)) : (cd[i] == 4'd0);
    end
  end

  assign sw.thr    = thr_m;
  assign sw.digits = {cd[3], cd[2], cd[1], cd[0]};

  // Entered and left at a falling edge; buttons held for exactly one rising edge.
  task automatic applyStimulus(input logic s, input logic p, input logic c);
    sw.start = s;
    sw.stop  = p;
    sw.clear = c;
    @(negedge clk);
    sw.start = 1'b0;
    sw.stop  = 1'b0;
    sw.clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw.start = 1'b0; sw.stop = 1'b0; sw.clear = 1'b0;
    sw.up_dn_in = 1'b1; sw.preset = 16'h0000;
`ifdef STOPWATCH_LAP_EN
    sw.lap = 1'b0;
`endif
    repeat (3) @(negedge clk);
    compared++; if (sw.cnt_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cnt_rst: got %b want 1", sw.cnt_rst); end
    compared++; if (sw.up_dn !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_up_dn: got %b want 1", sw.up_dn); end
    compared++; if (sw.rst_val !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_rst_val: got %h want 0000", sw.rst_val); end
    compared++; if (sw.en !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_en: got %b want 0000", sw.en); end
    compared++; if (sw.running !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_running: got %b want 0", sw.running); end
    compared++; if (sw.done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", sw.done); end
    reset = 1'b0;
    @(negedge clk);
    compared++; if (sw.cnt_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cnt_rst_release: got %b want 0", sw.cnt_rst); end
    compared++; if (sw.disp_digits !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_disp: got %h want 0000", sw.disp_digits); end
  endtask

  task automatic test_up_count();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 240; i++) begin
      compared++; if (sw.en[0] !== (i % 4 == 0)) begin mismatched++; $display("[TB] FAIL up_en0 cycle %0d: got %b want %b", i, sw.en[0], (i % 4 == 0)); end
      if (i == 240) begin
        compared++; if (sw.en !== 4'b0111) begin mismatched++; $display("[TB] FAIL up_en_carry_0059: got %b want 0111", sw.en); end
      end
      @(negedge clk);
    end
    compared++; if (sw.disp_digits !== 16'h0100) begin mismatched++; $display("[TB] FAIL up_digits_0100: got %h want 0100", sw.disp_digits); end
    compared++; if (sw.running !== 1'b1) begin mismatched++; $display("[TB] FAIL up_running: got %b want 1", sw.running); end
  endtask

  task automatic test_clear_priority_up();
    applyStimulus(1'b1, 1'b1, 1'b1);
    compared++; if (sw.running !== 1'b0 || sw.done !== 1'b0) begin mismatched++; $display("[TB] FAIL clrpri_up_state: got running=%b done=%b want 0 0", sw.running, sw.done); end
    compared++; if (sw.cnt_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL clrpri_up_cnt_rst: got %b want 1", sw.cnt_rst); end
    compared++; if (sw.rst_val !== 16'h0000) begin mismatched++; $display("[TB] FAIL clrpri_up_rst_val: got %h want 0000", sw.rst_val); end
    @(negedge clk);
    compared++; if (sw.cnt_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL clrpri_up_cnt_rst_pulse: got %b want 0", sw.cnt_rst); end
    compared++; if (sw.disp_digits !== 16'h0000) begin mismatched++; $display("[TB] FAIL clrpri_up_disp: got %h want 0000", sw.disp_digits); end
  endtask

  task automatic test_down_count();
    sw.up_dn_in = 1'b0;
    sw.preset   = 16'h0002;
    repeat (2) @(negedge clk);
    compared++; if (sw.up_dn !== 1'b0) begin mismatched++; $display("[TB] FAIL down_up_dn: got %b want 0", sw.up_dn); end
    applyStimulus(1'b0, 1'b0, 1'b1);
    compared++; if (sw.rst_val !== 16'h0002) begin mismatched++; $display("[TB] FAIL down_rst_val: got %h want 0002", sw.rst_val); end
    @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0002) begin mismatched++; $display("[TB] FAIL down_preset_loaded: got %h want 0002", sw.disp_digits); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      compared++; if (sw.en !== ((i % 4 == 0) ? 4'b0001 : 4'b0000)) begin mismatched++; $display("[TB] FAIL down_en cycle %0d: got %b want %b", i, sw.en, ((i % 4 == 0) ? 4'b0001 : 4'b0000)); end
      @(negedge clk);
    end
    compared++; if (sw.disp_digits !== 16'h0000) begin mismatched++; $display("[TB] FAIL down_reach_0000: got %h want 0000", sw.disp_digits); end
    compared++; if (sw.done !== 1'b0 || sw.running !== 1'b1) begin mismatched++; $display("[TB] FAIL down_pre_done: got running=%b done=%b want 1 0", sw.running, sw.done); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      compared++; if (sw.done !== 1'b1 || sw.running !== 1'b0) begin mismatched++; $display("[TB] FAIL down_done cycle %0d: got running=%b done=%b want 0 1", i, sw.running, sw.done); end
      compared++; if (sw.en !== 4'b0000) begin mismatched++; $display("[TB] FAIL down_done_en cycle %0d: got %b want 0000", i, sw.en); end
      compared++; if (sw.disp_digits !== 16'h0000) begin mismatched++; $display("[TB] FAIL down_done_disp cycle %0d: got %h want 0000", i, sw.disp_digits); end
      @(negedge clk);
    end
  endtask

  task automatic test_done_hold();
    applyStimulus(1'b1, 1'b1, 1'b0);
    compared++; if (sw.done !== 1'b1 || sw.running !== 1'b0) begin mismatched++; $display("[TB] FAIL done_ignores_buttons: got running=%b done=%b want 0 1", sw.running, sw.done); end
    applyStimulus(1'b0, 1'b0, 1'b1);
    compared++; if (sw.done !== 1'b0 || sw.running !== 1'b0) begin mismatched++; $display("[TB] FAIL done_clear_state: got running=%b done=%b want 0 0", sw.running, sw.done); end
    compared++; if (sw.cnt_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL done_clear_cnt_rst: got %b want 1", sw.cnt_rst); end
    @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0002) begin mismatched++; $display("[TB] FAIL done_clear_reload: got %h want 0002", sw.disp_digits); end
  endtask

  task automatic test_clear_priority_down();
    applyStimulus(1'b1, 1'b0, 1'b0);
    compared++; if (sw.running !== 1'b1) begin mismatched++; $display("[TB] FAIL clrpri_dn_start: got %b want 1", sw.running); end
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1);
    compared++; if (sw.running !== 1'b0 || sw.done !== 1'b0) begin mismatched++; $display("[TB] FAIL clrpri_dn_state: got running=%b done=%b want 0 0", sw.running, sw.done); end
    compared++; if (sw.cnt_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL clrpri_dn_cnt_rst: got %b want 1", sw.cnt_rst); end
    compared++; if (sw.rst_val !== 16'h0002) begin mismatched++; $display("[TB] FAIL clrpri_dn_rst_val: got %h want 0002", sw.rst_val); end
    @(negedge clk);
    compared++; if (sw.cnt_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL clrpri_dn_cnt_rst_pulse: got %b want 0", sw.cnt_rst); end
  endtask

  task automatic test_pause();
    sw.up_dn_in = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    compared++; if (sw.rst_val !== 16'h0000) begin mismatched++; $display("[TB] FAIL pause_prep_rst_val: got %h want 0000", sw.rst_val); end
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      compared++; if (sw.en !== 4'b0000 || sw.running !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_idle cycle %0d: got en=%b running=%b want 0000 0", i, sw.en, sw.running); end
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    compared++; if (sw.en[0] !== 1'b0 || sw.running !== 1'b1) begin mismatched++; $display("[TB] FAIL pause_resume1: got en0=%b running=%b want 0 1", sw.en[0], sw.running); end
    @(negedge clk);
    compared++; if (sw.en[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_resume2: got %b want 0", sw.en[0]); end
    @(negedge clk);
    compared++; if (sw.en !== 4'b0001) begin mismatched++; $display("[TB] FAIL pause_resume_tick: got %b want 0001", sw.en); end
    @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0001) begin mismatched++; $display("[TB] FAIL pause_digits: got %h want 0001", sw.disp_digits); end
  endtask

  task automatic test_reset_mid_run();
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0000) begin mismatched++; $display("[TB] FAIL midrst_prep: got %h want 0000", sw.disp_digits); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    sw.up_dn_in = 1'b0;
    repeat (828) @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0327) begin mismatched++; $display("[TB] FAIL midrst_at_0327: got %h want 0327", sw.disp_digits); end
    compared++; if (sw.up_dn !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_up_dn_frozen: got %b want 1", sw.up_dn); end
    reset = 1'b1;
    @(negedge clk);
    compared++; if (sw.running !== 1'b0 || sw.done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_state: got running=%b done=%b want 0 0", sw.running, sw.done); end
    compared++; if (sw.cnt_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_cnt_rst: got %b want 1", sw.cnt_rst); end
    compared++; if (sw.en !== 4'b0000) begin mismatched++; $display("[TB] FAIL midrst_en: got %b want 0000", sw.en); end
    reset = 1'b0;
    @(negedge clk);
    compared++; if (sw.up_dn !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_up_dn_idle_load: got %b want 0", sw.up_dn); end
    compared++; if (sw.disp_digits !== 16'h0000) begin mismatched++; $display("[TB] FAIL midrst_disp: got %h want 0000", sw.disp_digits); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    sw.up_dn_in = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0005) begin mismatched++; $display("[TB] FAIL lap_at_0005: got %h want 0005", sw.disp_digits); end
    sw.lap = 1'b1;
    @(negedge clk);
    sw.lap = 1'b0;
    repeat (8) @(negedge clk);
    compared++; if (sw.disp_digits !== 16'h0005) begin mismatched++; $display("[TB] FAIL lap_hold: got %h want 0005", sw.disp_digits); end
    sw.lap = 1'b1;
    @(negedge clk);
    sw.lap = 1'b0;
    compared++; if (sw.disp_digits !== 16'h0007) begin mismatched++; $display("[TB] FAIL lap_release: got %h want 0007", sw.disp_digits); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_count();
    test_clear_priority_up();
    test_down_count();
    test_done_hold();
    test_clear_priority_down();
    test_pause();
    test_reset_mid_run();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
